// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encoding and the
// default reset PC / sequential step. FETCH_MISALIGN_CHECK_EN adds the
// FAULT state used for misaligned redirect targets.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    FAULT
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch control FSM: state register, next-state logic, drop flag for a
// response orphaned by a redirect, and the registered request/valid outputs.
// With FETCH_MISALIGN_CHECK_EN a misaligned redirect parks the FSM in FAULT
// and raises a sticky fault flag.
//
// Handshakes: imem request is transferred on a cycle where imem_req and
// imem_ready are both high; the response is the single cycle where
// imem_rvalid is high while in WAIT; the instruction is transferred to decode
// on a cycle where instr_valid and instr_ready are both high. At most one
// memory request is ever outstanding.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         redir_i,        // redirect accepted this cycle
  input  logic         redir_bad_i,    // redirect target is misaligned
  input  logic         imem_ready_i,
  input  logic         imem_rvalid_i,
  input  logic         instr_ready_i,
  output fetch_state_e state_o,        // debug view of the current state
  output logic         imem_req_o,
  output logic         instr_valid_o,
  output logic         capture_o,      // load instr/instr_pc this cycle
  output logic         advance_o,      // PC <= PC + step this cycle
  output logic         fault_o
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic         req_q;
  logic         valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic         fault_q, fault_d;
`endif

  // Next-state, drop flag and datapath strobes
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    capture_o = 1'b0;
    advance_o = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redir_i) begin
          // If memory takes the stale request in the same cycle its answer
          // must still be drained, so wait for it with the drop flag set.
          state_d = imem_ready_i ? WAIT : REQ;
          drop_d  = imem_ready_i;
        end else if (imem_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir_i) begin
          if (imem_rvalid_i) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_q) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            capture_o = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_i) begin
          state_d = REQ;
        end else if (instr_ready_i) begin
          advance_o = 1'b1;
          state_d   = REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (redir_i && redir_bad_i) begin
      state_d   = FAULT;
      fault_d   = 1'b1;
      drop_d    = 1'b0;
      capture_o = 1'b0;
      advance_o = 1'b0;
    end
`endif
  end

  // State, drop flag and registered request/valid outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == HOLD);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign fault_o = fault_q;
`else
  logic unused_bad;
  assign unused_bad = redir_bad_i;
  assign fault_o    = 1'b0;
`endif

  assign state_o    = state_q;
  assign imem_req_o = req_q;
  // A redirect in HOLD withdraws the instruction in that same cycle; the
  // decode-side ready never reaches this output.
  assign instr_valid_o = valid_q && !redir_i;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit top: PC register, redirect target handling, captured
// instruction/PC registers and the fetch_fsm controller.
// Macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky
// fetch_fault; when undefined the low two target bits are forced to zero.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_step,
  output logic        fetch_fault
);

  fetch_state_e fsm_state;
  logic         redir_take;
  logic         redir_bad;
  logic         capture;
  logic         advance;
  logic [31:0]  tgt;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt       = redirect_target;
  assign redir_bad = (redirect_target[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;
  assign tgt            = {redirect_target[31:2], 2'b00};
  assign redir_bad      = 1'b0;
  assign unused_tgt_lsb = ^redirect_target[1:0];
`endif

  // Redirects only matter while a fetch is in flight (not in IDLE/FAULT)
  assign redir_take = redirect_valid &&
                      ((fsm_state == REQ) || (fsm_state == WAIT) || (fsm_state == HOLD));

  fetch_fsm u_fsm (
    .clk           (clk),
    .reset         (reset),
    .redir_i       (redir_take),
    .redir_bad_i   (redir_bad),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .instr_ready_i (instr_ready),
    .state_o       (fsm_state),
    .imem_req_o    (imem_req),
    .instr_valid_o (instr_valid),
    .capture_o     (capture),
    .advance_o     (advance),
    .fault_o       (fetch_fault)
  );

  // Next PC: redirect beats the sequential step; arithmetic wraps mod 2^32
  always_comb begin
    pc_d = pc_q;
    if (redir_take)   pc_d = tgt;
    else if (advance) pc_d = pc_q + PC_STEP;
  end

  // PC register and captured instruction/address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc_q;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign pc_plus_step = instr_pc_q + PC_STEP;

endmodule
